// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the Phase-1 control path: opcodes, sequencer states,
// ALU select bit positions and IR field positions.
package cpu_defs_pkg;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    localparam int ALU_W    = 13;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_MUL  = 2;
    localparam int ALU_DIV  = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    localparam int IR_OP_HI = 31;
    localparam int IR_RA_HI = 26;
    localparam int IR_RB_HI = 22;
    localparam int IR_RC_HI = 18;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_BINARY,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_HALT
    } op_class_e;

    // Undefined opcodes fall into CLS_NONE and behave exactly like NOP.
    function automatic op_class_e opClass(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL: opClass = CLS_BINARY;
            OP_MUL, OP_DIV:          opClass = CLS_MULDIV;
            OP_NEG, OP_NOT:          opClass = CLS_UNARY;
            OP_HALT:                 opClass = CLS_HALT;
            default:                 opClass = CLS_NONE;
        endcase
    endfunction

    function automatic logic [ALU_W-1:0] aluSelect(input logic [4:0] op);
        aluSelect = '0;
        case (op)
            OP_ADD:  aluSelect[ALU_ADD]  = 1'b1;
            OP_SUB:  aluSelect[ALU_SUB]  = 1'b1;
            OP_MUL:  aluSelect[ALU_MUL]  = 1'b1;
            OP_DIV:  aluSelect[ALU_DIV]  = 1'b1;
            OP_AND:  aluSelect[ALU_AND]  = 1'b1;
            OP_OR:   aluSelect[ALU_OR]   = 1'b1;
            OP_SHR:  aluSelect[ALU_SHR]  = 1'b1;
            OP_SHRA: aluSelect[ALU_SHRA] = 1'b1;
            OP_SHL:  aluSelect[ALU_SHL]  = 1'b1;
            OP_ROR:  aluSelect[ALU_ROR]  = 1'b1;
            OP_ROL:  aluSelect[ALU_ROL]  = 1'b1;
            OP_NEG:  aluSelect[ALU_NEG]  = 1'b1;
            OP_NOT:  aluSelect[ALU_NOT]  = 1'b1;
            default: aluSelect = '0;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// Turns a 4-bit register field into a one-hot enable vector, all zero when disabled.
module reg_select
    import cpu_defs_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic [3:0]      field_i,
    input  logic            en_i,
    output logic [NREG-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[field_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore sequencer stepping the Phase-1 Datapath through fetch (T0-T2) and the
// execute steps (T3-T6) of register-format ALU instructions.
module control_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      IR,
    output logic [NREG-1:0]  Rin,
    output logic [NREG-1:0]  Rout,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             MDMuxread,
    output logic             IRin,
    output logic             Yin,
    output logic             Zhighin,
    output logic             Zlowin,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             HIin,
    output logic             LOin,
    output logic [ALU_W-1:0] alu_op,
    output logic             halted,
    output logic             instr_done
);

    logic [3:0]      state_q, state_d;
    logic            t1Held_q, t1Held_d;
    logic [OPW-1:0]  opcode;
    op_class_e       cls;
    logic [ALU_W-1:0] aluSel;
    logic [3:0]      nextAfterLast;
    logic            raEn, rbEn, rcEn;
    logic [NREG-1:0] routB, routC;
    logic            unusedIrLow;

    assign opcode        = IR[IR_OP_HI -: OPW];
    assign cls           = opClass(opcode);
    assign aluSel        = aluSelect(opcode);
    assign nextAfterLast = run ? ST_T0 : ST_IDLE;
    assign unusedIrLow   = ^IR[14:0];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= ST_IDLE;
            t1Held_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            t1Held_q <= t1Held_d;
        end
    end

    // Remembers that T1 has already been spent waiting, so PC is loaded only once.
    assign t1Held_d = (state_q == ST_T1) && !mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = run ? ST_T0 : ST_IDLE;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = mem_ready ? ST_T2 : ST_T1;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                case (cls)
                    CLS_HALT: state_d = ST_HALT;
                    CLS_NONE: state_d = nextAfterLast;
                    default:  state_d = ST_T4;
                endcase
            end
            ST_T4:   state_d = (cls == CLS_UNARY) ? nextAfterLast : ST_T5;
            ST_T5:   state_d = (cls == CLS_MULDIV) ? ST_T6 : nextAfterLast;
            ST_T6:   state_d = nextAfterLast;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; MDMuxread = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zhighin = 1'b0; Zlowin = 1'b0; Zhighout = 1'b0;
        Zlowout = 1'b0; HIin = 1'b0; LOin = 1'b0; alu_op = '0;
        halted = 1'b0; instr_done = 1'b0;
        raEn = 1'b0; rbEn = 1'b0; rcEn = 1'b0;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1; PCin = !t1Held_q; MDMuxread = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_BINARY, CLS_MULDIV: begin
                        rbEn = 1'b1; Yin = 1'b1;
                    end
                    CLS_UNARY: begin
                        rbEn = 1'b1; alu_op = aluSel; Zlowin = 1'b1;
                    end
                    CLS_NONE: instr_done = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                if (cls == CLS_UNARY) begin
                    Zlowout = 1'b1; raEn = 1'b1; instr_done = 1'b1;
                end else begin
                    rcEn = 1'b1; alu_op = aluSel; Zlowin = 1'b1;
                    Zhighin = (cls == CLS_MULDIV);
                end
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (cls == CLS_MULDIV) begin
                    LOin = 1'b1;
                end else begin
                    raEn = 1'b1; instr_done = 1'b1;
                end
            end
            ST_T6: begin
                Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    reg_select #(.NREG(NREG)) u_rinSel (
        .field_i  (IR[IR_RA_HI -: 4]),
        .en_i     (raEn),
        .onehot_o (Rin)
    );

    reg_select #(.NREG(NREG)) u_routBSel (
        .field_i  (IR[IR_RB_HI -: 4]),
        .en_i     (rbEn),
        .onehot_o (routB)
    );

    reg_select #(.NREG(NREG)) u_routCSel (
        .field_i  (IR[IR_RC_HI -: 4]),
        .en_i     (rcEn),
        .onehot_o (routC)
    );

    assign Rout = routB | routC;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table vectors, random instruction
// streams against a step-list reference model, HALT hold and async abort.
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcOut, pcIn, incPc, marIn, mdrIn, mdrOut, mdMuxRead, irIn, yIn;
        logic zHighIn, zLowIn, zHighOut, zLowOut, hiIn, loIn;
        logic [12:0] aluOp;
        logic halted, instrDone;
    } outs_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        bit          runLast;
        int          expLat;
    } vec_t;

    logic        clock, clear, run, memReady;
    logic [31:0] ir;
    logic [15:0] rin, rout;
    logic pcOut, pcIn, incPc, marIn, mdrIn, mdrOut, mdMuxRead, irIn, yIn;
    logic zHighIn, zLowIn, zHighOut, zLowOut, hiIn, loIn;
    logic [12:0] aluOp;
    logic halted, instrDone;

    int          checks = 0;
    int          errors = 0;
    outs_t       expQ[$];
    logic [31:0] irPrev = 32'h0;
    vec_t        vecs[10];

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(memReady), .IR(ir),
        .Rin(rin), .Rout(rout), .PCout(pcOut), .PCin(pcIn), .IncPC(incPc),
        .MARin(marIn), .MDRin(mdrIn), .MDRout(mdrOut), .MDMuxread(mdMuxRead),
        .IRin(irIn), .Yin(yIn), .Zhighin(zHighIn), .Zlowin(zLowIn),
        .Zhighout(zHighOut), .Zlowout(zLowOut), .HIin(hiIn), .LOin(loIn),
        .alu_op(aluOp), .halted(halted), .instr_done(instrDone)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] mkIr(input int op, input int ra, input int rb, input int rc);
        mkIr = {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'h0};
    endfunction

    // ALU select position follows the documented list, ADD first.
    function automatic logic [12:0] aluOneHot(input logic [4:0] op);
        int order[13] = '{3, 4, 15, 16, 5, 6, 9, 10, 11, 7, 8, 17, 18};
        aluOneHot = '0;
        for (int i = 0; i < 13; i++) begin
            if (order[i] == int'(op)) aluOneHot[i] = 1'b1;
        end
    endfunction

    // Reference model: the list of control words one instruction should produce.
    function automatic void buildSeq(input logic [31:0] instr, input int waits);
        logic [4:0]  op = instr[31:27];
        logic [15:0] ra = 16'h1 << instr[26:23];
        logic [15:0] rb = 16'h1 << instr[22:19];
        logic [15:0] rc = 16'h1 << instr[18:15];
        bit isBin = op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
        bit isMd  = op inside {5'd15, 5'd16};
        bit isUn  = op inside {5'd17, 5'd18};
        outs_t o;
        expQ.delete();
        o = '0; o.pcOut = 1; o.marIn = 1; o.incPc = 1; o.zLowIn = 1; expQ.push_back(o);
        for (int w = 0; w <= waits; w++) begin
            o = '0; o.zLowOut = 1; o.mdMuxRead = 1; o.mdrIn = 1; o.pcIn = (w == 0);
            expQ.push_back(o);
        end
        o = '0; o.mdrOut = 1; o.irIn = 1; expQ.push_back(o);
        if (isBin || isMd) begin
            o = '0; o.rout = rb; o.yIn = 1; expQ.push_back(o);
            o = '0; o.rout = rc; o.aluOp = aluOneHot(op); o.zLowIn = 1; o.zHighIn = isMd;
            expQ.push_back(o);
            if (isBin) begin
                o = '0; o.zLowOut = 1; o.rin = ra; o.instrDone = 1; expQ.push_back(o);
            end else begin
                o = '0; o.zLowOut = 1; o.loIn = 1; expQ.push_back(o);
                o = '0; o.zHighOut = 1; o.hiIn = 1; o.instrDone = 1; expQ.push_back(o);
            end
        end else if (isUn) begin
            o = '0; o.rout = rb; o.aluOp = aluOneHot(op); o.zLowIn = 1; expQ.push_back(o);
            o = '0; o.zLowOut = 1; o.rin = ra; o.instrDone = 1; expQ.push_back(o);
        end else begin
            o = '0; o.instrDone = (op != 5'd27); expQ.push_back(o);
        end
    endfunction

    function automatic outs_t sampleOuts();
        outs_t a;
        a = {rin, rout, pcOut, pcIn, incPc, marIn, mdrIn, mdrOut, mdMuxRead, irIn, yIn,
             zHighIn, zLowIn, zHighOut, zLowOut, hiIn, loIn, aluOp, halted, instrDone};
        return a;
    endfunction

    task automatic compareOuts(input string name, input outs_t act, input outs_t exp);
        int drivers;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: outputs got %h expected %h", name, $time, act, exp);
        end
        drivers = $countones(act.rout) + act.zHighOut + act.zLowOut + act.mdrOut + act.pcOut;
        checks++;
        if (drivers > 1) begin
            errors++;
            $display("[TB] FAIL %s_bus @%0t: bus drivers got %0d expected <=1", name, $time, drivers);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic m, input logic [31:0] instr);
        run = r;
        memReady = m;
        ir = instr;
    endtask

    task automatic checkOutput(input string name, input outs_t exp, output outs_t act);
        @(negedge clock);
        act = sampleOuts();
        compareOuts(name, act, exp);
        @(posedge clock);
        #1;
    endtask

    // Expects to be entered at the start of a T0 cycle; leaves the DUT about to enter T0
    // unless the instruction halts or is aborted.
    task automatic runInstr(input string name, input logic [31:0] instr, input int waits,
                            input bit runLast, input int expLat, input int abortAt);
        outs_t act;
        int    doneAt = -1;
        buildSeq(instr, waits);
        for (int i = 0; i < expQ.size(); i++) begin
            bit isT1 = (i >= 1) && (i <= waits + 1);
            logic m = isT1 ? (i == waits + 1) : 1'($urandom % 2);
            logic r = (i == expQ.size() - 1) ? runLast : 1'($urandom % 2);
            applyStimulus(r, m, (i >= waits + 3) ? instr : irPrev);
            if (i == abortAt) begin
                #2;
                compareOuts({name, "_pre"}, sampleOuts(), expQ[i]);
                clear = 1'b0;
                #1;
                compareOuts({name, "_now"}, sampleOuts(), '0);
                @(negedge clock);
                compareOuts({name, "_hold"}, sampleOuts(), '0);
                @(posedge clock);
                #1;
                irPrev = instr;
                return;
            end
            checkOutput($sformatf("%s_s%0d", name, i), expQ[i], act);
            if (act.instrDone === 1'b1 && doneAt < 0) doneAt = i;
        end
        irPrev = instr;
        if (expLat > 0) begin
            checks++;
            if (doneAt + 1 != expLat) begin
                errors++;
                $display("[TB] FAIL %s_latency: got %0d cycles expected %0d", name, doneAt + 1, expLat);
            end
        end
        if (!runLast) begin
            int idles = $urandom_range(0, 2);
            for (int k = 0; k < idles; k++) begin
                applyStimulus(1'b0, 1'($urandom % 2), $urandom);
                checkOutput({name, "_idle"}, '0, act);
            end
            applyStimulus(1'b1, 1'($urandom % 2), irPrev);
            checkOutput({name, "_idlerun"}, '0, act);
        end
    endtask

    initial begin
        outs_t act;
        outs_t haltWord;
        vecs[0] = '{32'h18918000,          0, 1'b1, 6};
        vecs[1] = '{mkIr(4, 4, 5, 6),      3, 1'b1, 9};
        vecs[2] = '{mkIr(15, 0, 4, 5),     0, 1'b1, 7};
        vecs[3] = '{mkIr(18, 6, 7, 0),     0, 1'b1, 5};
        vecs[4] = '{mkIr(26, 1, 2, 3),     0, 1'b0, 4};
        vecs[5] = '{mkIr(16, 9, 9, 9),     1, 1'b1, 8};
        vecs[6] = '{mkIr(17, 15, 14, 13),  2, 1'b1, 7};
        vecs[7] = '{mkIr(31, 3, 3, 3),     0, 1'b1, 4};
        vecs[8] = '{mkIr(8, 12, 0, 15),    0, 1'b0, 6};
        vecs[9] = '{mkIr(10, 2, 11, 1),    1, 1'b1, 7};

        clear = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (2) checkOutput("reset", '0, act);
        clear = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0);
        repeat (2) checkOutput("idle_run0", '0, act);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("idle_run1", '0, act);

        for (int v = 0; v < 10; v++) begin
            runInstr($sformatf("vec%0d", v), vecs[v].ir, vecs[v].waits, vecs[v].runLast,
                     vecs[v].expLat, -1);
        end

        for (int n = 0; n < 40; n++) begin
            int op = $urandom_range(0, 31);
            if (op == 27) op = 26;
            runInstr($sformatf("rnd%0d", n),
                     mkIr(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                     $urandom_range(0, 3), ($urandom % 4) != 0, 0, -1);
        end

        runInstr("halt", mkIr(27, 1, 2, 3), 0, 1'b1, 0, -1);
        haltWord = '0;
        haltWord.halted = 1'b1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'($urandom % 2), 1'($urandom % 2), irPrev);
            checkOutput("halt_hold", haltWord, act);
        end

        clear = 1'b0;
        applyStimulus(1'b1, 1'b1, irPrev);
        checkOutput("halt_reset", '0, act);
        clear = 1'b1;
        checkOutput("after_halt_idle", '0, act);

        runInstr("abort", mkIr(3, 1, 2, 3), 0, 1'b1, 0, 4);
        clear = 1'b1;
        applyStimulus(1'b0, 1'b1, irPrev);
        repeat (2) checkOutput("abort_idle", '0, act);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
